// File: rtl/posit_encoder_if.sv
// Valid/ready bundle between the normalise stage and the posit encoder.
// The master drives the fields and out_ready; the slave returns in_ready, out_valid and q.
`timescale 1ns/1ps
interface posit_encoder_if #(
  parameter int WIDTH = 7,
  parameter int MW    = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic             in_zero;
  logic             in_nar;
  logic [7:0]       in_regime;
  logic [7:0]       in_exponent;
  logic [MW-1:0]    in_mantissa;
  logic             in_sticky;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;

  modport master (
    output in_valid, in_sign, in_zero, in_nar, in_regime, in_exponent,
           in_mantissa, in_sticky, out_ready,
    input  in_ready, out_valid, q
  );

  modport slave (
    input  in_valid, in_sign, in_zero, in_nar, in_regime, in_exponent,
           in_mantissa, in_sticky, out_ready,
    output in_ready, out_valid, q
  );
endinterface

// File: rtl/posit_encoder.sv
// Posit encoder: packs sign/regime/exponent/fraction into a WIDTH-bit posit with
// round-to-nearest-even, saturation and zero/NaR handling, in two valid/ready stages.
`timescale 1ns/1ps
module posit_encoder #(
  parameter int WIDTH = 7,
  parameter int EN    = 1,
  parameter int MW    = 8
) (
  input logic            clk,
  input logic            rst,
  posit_encoder_if.slave bus
);
  localparam int BW = WIDTH - 1;        // unsigned body width
  localparam int TW = EN + MW;          // exponent + fraction tail
  localparam int XW = BW + 1 + TW;      // long enough that nothing is lost before guard/sticky
  localparam logic signed [7:0] K_MAX = 8'(WIDTH - 2);
  localparam logic signed [7:0] K_MIN = 8'(-(WIDTH - 2));
  localparam logic [WIDTH-1:0] NAR_WORD = {1'b1, {(WIDTH-1){1'b0}}};

  logic s1_en;
  logic s2_en;

  logic          s1_valid_reg;
  logic [BW-1:0] s1_body_reg;
  logic          s1_guard_reg;
  logic          s1_sticky_reg;
  logic          s1_sign_reg;
  logic          s1_zero_reg;
  logic          s1_nar_reg;

  logic             s2_valid_reg;
  logic [WIDTH-1:0] q_reg;

  assign s2_en        = ~s2_valid_reg | bus.out_ready;
  assign s1_en        = ~s1_valid_reg | s2_en;
  assign bus.in_ready = s1_en & ~rst;
  assign bus.out_valid = s2_valid_reg;
  assign bus.q         = q_reg;

  logic [TW-1:0] tail;
  generate
    if (EN > 0) begin : g_exp
      logic unused_exp;
      assign tail       = {bus.in_exponent[EN-1:0], bus.in_mantissa};
      assign unused_exp = ^bus.in_exponent[7:EN];
    end else begin : g_noexp
      logic unused_exp;
      assign tail       = bus.in_mantissa;
      assign unused_exp = ^bus.in_exponent;
    end
  endgenerate

  logic signed [7:0] k;
  logic              k_neg;
  logic [7:0]        k_mag;
  logic [7:0]        regime_len;
  assign k          = bus.in_regime;
  assign k_neg      = k[7];
  assign k_mag      = k_neg ? 8'(-k) : 8'(k);
  assign regime_len = k_neg ? (k_mag + 8'd1) : (k_mag + 8'd2);

  // Regime pattern, MSB first: k>=0 gives k+1 ones then zeros; k<0 gives a single 1 at offset -k.
  logic [XW-1:0] regime_bits;
  generate
    for (genvar gi = 0; gi < XW; gi++) begin : g_regime
      assign regime_bits[XW-1-gi] = k_neg ? (k_mag == 8'(gi)) : (8'(gi) <= k_mag);
    end
  endgenerate

  logic [XW-1:0] ext_bits;
  logic [BW-1:0] s1_body_next;
  logic          s1_guard_next;
  logic          s1_sticky_next;

  always_comb begin
    ext_bits       = regime_bits | ({tail, {(BW+1){1'b0}}} >> regime_len);
    s1_body_next   = ext_bits[XW-1 -: BW];
    s1_guard_next  = ext_bits[TW];
    s1_sticky_next = (|ext_bits[TW-1:0]) | bus.in_sticky;
    // Saturated values are exact by construction: clear guard/sticky so S2 never rounds them.
    if (k >= K_MAX) begin
      s1_body_next   = {BW{1'b1}};
      s1_guard_next  = 1'b0;
      s1_sticky_next = 1'b0;
    end else if (k <= K_MIN) begin
      s1_body_next   = BW'(1);
      s1_guard_next  = 1'b0;
      s1_sticky_next = 1'b0;
    end
  end

  logic             round_up;
  logic [BW-1:0]    body_rnd;
  logic [WIDTH-1:0] pos_word;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    round_up = s1_guard_reg & (s1_sticky_reg | s1_body_reg[0]);
    body_rnd = s1_body_reg + BW'(round_up);
    pos_word = {1'b0, body_rnd};
    q_next   = s1_sign_reg ? (~pos_word + WIDTH'(1)) : pos_word;
    if (s1_nar_reg) begin
      q_next = NAR_WORD;
    end else if (s1_zero_reg) begin
      q_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      q_reg        <= '0;
    end else begin
      if (s1_en) begin
        s1_valid_reg <= bus.in_valid;
        if (bus.in_valid) begin
          s1_body_reg   <= s1_body_next;
          s1_guard_reg  <= s1_guard_next;
          s1_sticky_reg <= s1_sticky_next;
          s1_sign_reg   <= bus.in_sign;
          s1_zero_reg   <= bus.in_zero;
          s1_nar_reg    <= bus.in_nar;
        end
      end
      if (s2_en) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          q_reg <= q_next;
        end
      end
    end
  end
endmodule
